rr_burst_scheduler: RTL and testbench
=====================================

Name: rr_burst_scheduler

Overview:
- Round-robin scheduler that shares one burst-oriented resource (bus/port) among N requesters.
- A winner keeps its grant for a full burst of (req_len+1) beats, counted on the resource's beat_done strobe.
- A watchdog forcibly releases a stalled owner.
- Sits between requester agents and the shared resource; the resource sees only gnt_idx/gnt_valid and returns beat_done.

Parameters:
- N, 4, number of requesters (2..16).
- LEN_W, 4, width of per-requester burst length field (beats-1).
- TIMEOUT, 64, max consecutive owner cycles without beat_done before forced release (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request vector, level; bit i = requester i wants the resource.
- req_len  in  N*LEN_W  burst length minus 1 for each requester, slice i = [i*LEN_W +: LEN_W]; sampled only at grant.
- beat_done  in  1  resource completed one beat of the current burst; ignored when gnt_valid=0.
- gnt  out  N  one-hot grant, registered.
- gnt_idx  out  clog2(N)  index of current owner, valid when gnt_valid=1, else 0.
- gnt_valid  out  1  a burst is in progress.
- beats_left  out  LEN_W  remaining beats minus 1 of current burst.
- timeout_err  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset: gnt=0, gnt_idx=0, gnt_valid=0, beats_left=0, timeout_err=0, state=IDLE, priority pointer ptr=0 (req0 highest), watchdog=0.
- State IDLE:
  - If |req, pick the first set bit searching ptr, ptr+1, ..., ptr+N-1 (mod N).
  - Next cycle: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, beats_left=req_len[winner], state=BURST.
  - Grant latency is 1 cycle from req seen in IDLE.
- State BURST:
  - beat_done=1 with beats_left>0: beats_left decrements, watchdog clears.
  - beat_done=1 with beats_left==0 (final beat): burst ends, ptr<=winner+1 mod N.
    - If any req is set that cycle, the new winner is picked using the updated pointer (the old owner is lowest priority) and granted on the next cycle, back-to-back with no bubble. beats_left is loaded from the new winner.
    - Else go to IDLE with gnt=0 and gnt_valid=0 next cycle.
  - beat_done=0: watchdog increments. When watchdog reaches TIMEOUT-1 without beat_done:
    - Force release: gnt=0, gnt_valid=0, timeout_err=1 for one cycle, ptr<=winner+1, state=IDLE.
    - No rearbitration that cycle, so there is exactly one bubble.
- The owner dropping req mid-burst does not release the grant; only the burst count or the timeout ends ownership.
- Changes to req_len after grant are ignored.
- gnt is always one-hot or zero; gnt_valid == |gnt.
- The watchdog counter width is clog2(TIMEOUT); it saturates and never wraps.
- Simultaneous final beat_done and timeout threshold: beat_done wins, so it is a normal completion with no timeout_err.
- req_len=0 is a single-beat burst; the grant lasts until the first beat_done.
- Pointer wrap: winner N-1 sets ptr=0.
- rst asserted mid-burst: all outputs return to reset values on the next edge, and the burst is abandoned without timeout_err.

Decomposition:
- Package rr_burst_pkg: state enum (IDLE, BURST), a function computing clog2 widths, and a constant for the reset pointer value.
- Sub-module rr_pick: purely combinational rotate-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: any, idx, onehot.
  - Instantiated once and reused for both the IDLE and end-of-burst arbitration paths.

Test Plan:
- Reset then req=4'b1111, all req_len=1, beat_done always 1 -> owners 0,1,2,3,0 in order; each holds gnt for 2 cycles, no bubble between bursts.
- req=4'b0100 only, req_len[2]=3 -> gnt=4'b0100 one cycle after req; beats_left 3,2,1,0; release after 4 beat_done; then IDLE with gnt=0.
- req=4'b1001 in IDLE, ptr=0 -> gnt0 first; on its final beat with both still requesting -> gnt3 next cycle (fairness; old owner lowest).
- Owner 1 granted, beat_done held 0, TIMEOUT=64 -> forced release after 64 cycles, timeout_err single pulse, gnt=0 for one cycle, then requester 2 is preferred.
- Owner drops req after first beat of a req_len=2 burst -> grant held until third beat_done.
- rst pulsed on cycle 2 of a 4-beat burst -> next cycle gnt=0, gnt_valid=0, beats_left=0, ptr=0; subsequent req=4'b1010 grants requester 1.

Source files
------------

// File: rtl/rr_burst_pkg.sv
// Shared types and helpers for the round-robin burst scheduler.
// Holds the FSM encoding, the width helper and the post-reset priority pointer.
package rr_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int PTR_RESET = 0;

  // Never returns 0 so that counters/indices always have at least one bit.
  function automatic int clog2_w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping mod N.
module rr_pick
  import rr_burst_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = clog2_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  logic [IW:0] pos;

  // Walk from the lowest priority slot up so the slot nearest ptr overwrites last.
  always_comb begin
    any    = |req;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(N)) pos = pos - (IW + 1)'(N);
      if (req[pos[IW-1:0]]) idx = pos[IW-1:0];
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_burst_scheduler.sv
// Round-robin owner of a burst resource: holds a grant for req_len+1 beats of beat_done,
// with a watchdog that force-releases an owner that stops producing beats.
module rr_burst_scheduler
  import rr_burst_pkg::*;
#(
  parameter int N       = 4,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 64,
  localparam int IW = clog2_w(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*LEN_W-1:0] req_len,
  input  logic               beat_done,
  output logic [N-1:0]       gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               gnt_valid,
  output logic [LEN_W-1:0]   beats_left,
  output logic               timeout_err,
  output logic               fsm_state
);

  localparam int WD_W = clog2_w(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t           state_q, state_nx;
  logic [IW-1:0]    ptr_q, ptr_nx;
  logic [WD_W-1:0]  wdog_q, wdog_nx;
  logic [N-1:0]     gnt_q, gnt_nx;
  logic [IW-1:0]    idx_q, idx_nx;
  logic             valid_q, valid_nx;
  logic [LEN_W-1:0] beats_q, beats_nx;
  logic             terr_q, terr_nx;

  logic [LEN_W-1:0] len_arr [N];
  logic [IW-1:0]    pick_ptr;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic [N-1:0]     pick_onehot;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) len_arr[i] = req_len[i*LEN_W +: LEN_W];
  end

  // One picker serves both paths: in BURST it only matters on the final beat,
  // where the rotated pointer makes the outgoing owner lowest priority.
  assign pick_ptr = (state_q == BURST) ? next_ptr(idx_q) : ptr_q;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(PTR_RESET);
      wdog_q  <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      beats_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      ptr_q   <= ptr_nx;
      wdog_q  <= wdog_nx;
      gnt_q   <= gnt_nx;
      idx_q   <= idx_nx;
      valid_q <= valid_nx;
      beats_q <= beats_nx;
      terr_q  <= terr_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    ptr_nx   = ptr_q;
    wdog_nx  = wdog_q;
    gnt_nx   = gnt_q;
    idx_nx   = idx_q;
    valid_nx = valid_q;
    beats_nx = beats_q;
    terr_nx  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_nx = BURST;
          gnt_nx   = pick_onehot;
          idx_nx   = pick_idx;
          valid_nx = 1'b1;
          beats_nx = len_arr[pick_idx];
          wdog_nx  = '0;
        end
      end
      BURST: begin
        if (beat_done) begin
          wdog_nx = '0;
          if (beats_q != '0) begin
            beats_nx = beats_q - 1'b1;
          end else begin
            ptr_nx = next_ptr(idx_q);
            if (pick_any) begin
              gnt_nx   = pick_onehot;
              idx_nx   = pick_idx;
              beats_nx = len_arr[pick_idx];
            end else begin
              state_nx = IDLE;
              gnt_nx   = '0;
              idx_nx   = '0;
              valid_nx = 1'b0;
              beats_nx = '0;
            end
          end
        end else if (wdog_q == WD_LAST) begin
          // Forced release skips arbitration, leaving exactly one idle cycle.
          state_nx = IDLE;
          ptr_nx   = next_ptr(idx_q);
          gnt_nx   = '0;
          idx_nx   = '0;
          valid_nx = 1'b0;
          beats_nx = '0;
          wdog_nx  = '0;
          terr_nx  = 1'b1;
        end else begin
          wdog_nx = wdog_q + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt         = gnt_q;
    gnt_idx     = idx_q;
    gnt_valid   = valid_q;
    beats_left  = beats_q;
    timeout_err = terr_q;
    fsm_state   = (state_q == BURST);
  end

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Directed bench for rr_burst_scheduler: expected values hand-derived from the
// round-robin/burst/watchdog behaviour, checked with immediate assertions.
module tb_rr_burst_scheduler;

  localparam int N       = 4;
  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*LEN_W-1:0] req_len;
  logic              beat_done;
  logic [N-1:0]      gnt;
  logic [1:0]        gnt_idx;
  logic              gnt_valid;
  logic [LEN_W-1:0]  beats_left;
  logic              timeout_err;
  logic              fsm_state;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  rr_burst_scheduler #(.N(N), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_len     (req_len),
    .beat_done   (beat_done),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .beats_left  (beats_left),
    .timeout_err (timeout_err),
    .fsm_state   (fsm_state)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk_all(input string tag, input logic [3:0] eg, input logic [3:0] eb, input logic et);
    chk({tag, ".gnt"},         32'(gnt),         32'(eg));
    chk({tag, ".gnt_idx"},     32'(gnt_idx),     32'(oh2idx(eg)));
    chk({tag, ".gnt_valid"},   32'(gnt_valid),   32'(|eg));
    chk({tag, ".beats_left"},  32'(beats_left),  32'(eb));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(et));
    chk({tag, ".fsm_state"},   32'(fsm_state),   32'(|eg));
  endtask

  initial begin
    logic [1:0] w;
    int held;

    rst = 1'b1; req = '0; req_len = '0; beat_done = 1'b0;
    step(2);
    chk_all("reset", 4'b0000, 4'd0, 1'b0);
    rst = 1'b0;

    // All four requesting, two-beat bursts, beat every cycle: 0,1,2,3,0 back to back.
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd0);
    req = 4'b1111; req_len = 16'h1111; beat_done = 1'b1;
    step();
    for (int o = 0; o < 5; o++) begin
      w = exp_q.pop_front();
      chk_all("rr_first", 4'b0001 << w, 4'd1, 1'b0);
      step();
      chk_all("rr_last", 4'b0001 << w, 4'd0, 1'b0);
      if (o == 4) req = 4'b0000;
      step();
    end
    chk_all("rr_idle", 4'b0000, 4'd0, 1'b0);
    beat_done = 1'b0;

    // Lone requester 2, four-beat burst (ptr is 1 here).
    req = 4'b0100; req_len = 16'h0300;
    step();
    chk_all("single_grant", 4'b0100, 4'd3, 1'b0);
    beat_done = 1'b1;
    step();
    chk_all("single_b2", 4'b0100, 4'd2, 1'b0);
    step();
    chk_all("single_b1", 4'b0100, 4'd1, 1'b0);
    step();
    chk_all("single_b0", 4'b0100, 4'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_all("single_rel", 4'b0000, 4'd0, 1'b0);
    beat_done = 1'b0;

    // Fairness from ptr=0: 0 first, then 3 (old owner lowest), then wrap back to 0.
    rst = 1'b1;
    step();
    chk_all("rst_idle", 4'b0000, 4'd0, 1'b0);
    rst = 1'b0; req = 4'b1001; req_len = 16'h0000;
    step();
    chk_all("fair_first", 4'b0001, 4'd0, 1'b0);
    beat_done = 1'b1;
    step();
    chk_all("fair_second", 4'b1000, 4'd0, 1'b0);
    req = 4'b0001;
    step();
    chk_all("fair_wrap", 4'b0001, 4'd0, 1'b0);
    req = 4'b0000;
    step();
    chk_all("fair_idle", 4'b0000, 4'd0, 1'b0);
    beat_done = 1'b0;

    // Watchdog: owner 1 stalls; grant lasts 64 cycles, one bubble with timeout_err, then 2.
    req = 4'b0110;
    step();
    chk_all("wd_grant", 4'b0010, 4'd0, 1'b0);
    held = 1;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      step();
      if (gnt === 4'b0010 && timeout_err === 1'b0) held++;
    end
    chk("wd_held_cycles", 32'(held), 32'(TIMEOUT));
    chk_all("wd_last_hold", 4'b0010, 4'd0, 1'b0);
    step();
    chk_all("wd_release", 4'b0000, 4'd0, 1'b1);
    step();
    chk_all("wd_next", 4'b0100, 4'd0, 1'b0);
    req = 4'b0000; beat_done = 1'b1;
    step();
    chk_all("wd_idle", 4'b0000, 4'd0, 1'b0);
    beat_done = 1'b0;

    // Owner 1 drops req mid-burst and req_len changes after grant: both ignored.
    req = 4'b0010; req_len = 16'h0020;
    step();
    chk_all("drop_grant", 4'b0010, 4'd2, 1'b0);
    req_len = 16'h00F0; beat_done = 1'b1;
    step();
    chk_all("drop_b1", 4'b0010, 4'd1, 1'b0);
    req = 4'b0000;
    step();
    chk_all("drop_b0", 4'b0010, 4'd0, 1'b0);
    step();
    chk_all("drop_rel", 4'b0000, 4'd0, 1'b0);
    beat_done = 1'b0;

    // Reset mid-burst abandons it silently and restores ptr=0.
    req = 4'b0100; req_len = 16'h0300;
    step();
    chk_all("rstm_grant", 4'b0100, 4'd3, 1'b0);
    beat_done = 1'b1;
    step();
    chk_all("rstm_b2", 4'b0100, 4'd2, 1'b0);
    rst = 1'b1;
    step();
    chk_all("rstm_cleared", 4'b0000, 4'd0, 1'b0);
    rst = 1'b0; beat_done = 1'b0; req = 4'b1010;
    step();
    chk_all("rstm_ptr0", 4'b0010, 4'd0, 1'b0);

    // Final beat arriving on the watchdog threshold cycle is a normal completion.
    step(TIMEOUT - 1);
    chk_all("tie_hold", 4'b0010, 4'd0, 1'b0);
    beat_done = 1'b1; req = 4'b0000;
    step();
    chk_all("tie_done", 4'b0000, 4'd0, 1'b0);
    beat_done = 1'b0; req = 4'b1111;
    step();
    chk_all("tie_ptr", 4'b0100, 4'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
